seq_alu: RTL and testbench
==========================

# seq_alu

Multi-cycle, parametrised N-bit ALU that succeeds the combinational lab ALU. It registers its operands on a start pulse and computes add, subtract, logic and shift operations in one cycle. Multiply and divide use iterative shift-add and restoring-divide datapaths. A result is presented with a one-cycle `done` pulse plus NZCV flags, so the block can sit behind a register file or a switch/LED front end in the lab top level.

## Interface
Parameters:
- `N`, default 4: operand width; legal range 2..32.

Ports:
- `clk`, in, 1: system clock; rising edge.
- `rst_n`, in, 1: reset, asynchronous, active-low.
- `start`, in, 1: request strobe; sampled only while `busy`=0.
- `op`, in, 4: opcode (see Operation).
- `a`, in, N: first operand.
- `b`, in, N: second operand.
- `result`, out, N: low result, or the quotient for DIV.
- `result_hi`, out, N: MUL high half, or the DIV remainder; 0 for other ops.
- `flags`, out, 4: {N, Z, C, V} of `result`.
- `err`, out, 1: divide-by-zero or unsupported opcode; valid with `done`.
- `busy`, out, 1: high from accepted start until `done`.
- `done`, out, 1: one-cycle pulse; results are valid from this cycle.

## Operation
- Opcodes: 0 ADD, 1 SUB (a−b), 2 AND, 3 OR, 4 XOR, 5 NOT a, 6 SHL a by b[log2N-1:0], 7 SHR (logical), 8 MUL (unsigned, 2N product), 9 DIV (unsigned). Codes 10..15 are unsupported.
- FSM states are IDLE, ITER and DONE.
- IDLE with `start`=1 latches `a`, `b` and `op`, then:
  - single-cycle op: go to DONE;
  - MUL, or DIV with b≠0: go to ITER with the iteration counter set to N.
- ITER: one shift-add or restore step per cycle. The counter decrements; at 0 go to DONE.
- DONE: drive `done`=1 and go to IDLE. `result`, `result_hi`, `flags` and `err` hold until the next accepted start completes.
- `start` while `busy`=1 is ignored and not queued.
- Flags:
  - Z = (`result`==0).
  - N = `result`[N-1].
  - C = carry-out for ADD; C = NOT borrow for SUB; C = last bit shifted out for SHL/SHR; C = (`result_hi`≠0) for MUL; otherwise 0.
  - V = signed overflow for ADD/SUB; otherwise 0.
- DIV with b=0:
  - `result` = all ones, `result_hi` = a, `err`=1, Z=0, N=1, C=0, V=0.
  - Single-cycle path; the block does not enter ITER.
- Unsupported opcode: `result`=0, `result_hi`=0, `err`=1; all flags 0, including Z; single-cycle path.
- Shift amount ≥ N: `result`=0 and C=0.
- All arithmetic is unsigned and modulo 2^N, except V, which interprets the operands as two's complement.

## Timing
- Reset (`rst_n`=0, asynchronous): state IDLE; `result`, `result_hi`, `flags`, `err`, `busy` and `done` all 0; counter 0.
- Reset mid-ITER aborts the operation. There is no `done` pulse, and the first start after reset release is accepted normally.
- Start is sampled on edge T0. `busy`=1 from T0 until the edge at which `done` falls; `busy` is low again in the cycle after `done`.
- Latency from the start edge to `done`:
  - single-cycle ops: 1 cycle (`done` high in the cycle after T0);
  - MUL and DIV (b≠0): N+1 cycles.
- A new start may be asserted in the cycle after `done`, so throughput is one op per 2 cycles, or per N+2 cycles for MUL/DIV.
- Outputs are registered; there is no combinational path from inputs to outputs.

## Configuration
- `SEQ_ALU_MULDIV_EN` defined:
  - MUL and DIV datapaths are compiled in and behave as above.
- `SEQ_ALU_MULDIV_EN` undefined:
  - Opcodes 8 and 9 are treated as unsupported: `err`=1, `result`=0, single-cycle latency.
  - The ITER state and the counter are not synthesised.

## Structure
- Package `seq_alu_pkg` holds:
  - the `alu_op_t` enum for opcodes 0..9;
  - the `state_t` enum {IDLE, ITER, DONE};
  - flag bit-index constants `FLAG_N`=3, `FLAG_Z`=2, `FLAG_C`=1, `FLAG_V`=0.
- Sub-module `seq_muldiv`, parametrised by N:
  - inputs: `start`, `mode` (mul/div), `a` and `b`;
  - outputs: `lo`, `hi` and `ready` after N cycles.
  - The whole instance sits under `SEQ_ALU_MULDIV_EN`.
- The top level holds the FSM, the single-cycle ops, flag generation and the output registers.

## Test plan
1. N=4, ADD a=7 b=9 -> `done` 1 cycle after start; `result`=0, flags Z=1 C=1 V=0 N=0.
2. N=4, SUB a=4 b=5 -> `result`=15, flags N=1 C=0 V=0; SUB a=8 b=1 -> `result`=7, V=1.
3. N=4, MUL a=15 b=15 -> `done` exactly 5 cycles after start, `busy` high for those 5 cycles; `result`=1, `result_hi`=14, C=1.
4. N=4, DIV a=13 b=4 -> `result`=3, `result_hi`=1, `err`=0; DIV a=9 b=0 -> 1-cycle latency, `result`=15, `result_hi`=9, `err`=1.
5. Start MUL, pulse `start` with an ADD during ITER, then assert `rst_n`=0 at cycle 3 -> ADD ignored; all outputs 0 immediately, no `done`; a following ADD 2+3 gives `result`=5.
6. Build with `SEQ_ALU_MULDIV_EN` undefined: MUL a=3 b=3 -> 1-cycle latency, `err`=1, `result`=0; opcode 12 -> `err`=1 in every build.

Source files
------------

// File: rtl/seq_alu_pkg.sv
// -----------------------------------------------------------------------------
// seq_alu_pkg
//   Shared types and constants for the sequential ALU and its mul/div datapath.
//   - alu_op_t  : opcode encoding (codes 10..15 are unsupported)
//   - state_t   : controller states
//   - md_mode_t : mul/div datapath mode select
//   - FLAG_*    : bit positions inside the 4-bit {N,Z,C,V} flag vector
// -----------------------------------------------------------------------------
package seq_alu_pkg;

   typedef enum logic [3:0] {
      OP_ADD = 4'd0,
      OP_SUB = 4'd1,
      OP_AND = 4'd2,
      OP_OR  = 4'd3,
      OP_XOR = 4'd4,
      OP_NOT = 4'd5,
      OP_SHL = 4'd6,
      OP_SHR = 4'd7,
      OP_MUL = 4'd8,
      OP_DIV = 4'd9
   } alu_op_t;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      ITER = 2'd1,
      DONE = 2'd2
   } state_t;

   typedef enum logic {
      MD_MUL = 1'b0,
      MD_DIV = 1'b1
   } md_mode_t;

   localparam int FLAG_N = 3;
   localparam int FLAG_Z = 2;
   localparam int FLAG_C = 1;
   localparam int FLAG_V = 0;

endpackage

// File: rtl/seq_muldiv.sv
// -----------------------------------------------------------------------------
// seq_muldiv
//   Iterative unsigned multiplier (shift-add, LSB first) and restoring divider.
//   The start edge loads the operands and already performs the first step, so
//   N steps are complete N-1 edges later and `ready` is high from then on.
//   Ports:
//     clk, rst_n    : clock, asynchronous active-low reset
//     start         : load a/b/mode and perform step 1
//     mode          : MD_MUL or MD_DIV
//     a, b          : operands (multiplier/multiplicand, dividend/divisor)
//     lo, hi        : MUL product low/high half, DIV quotient/remainder
//     ready         : all N steps done; lo/hi valid
// -----------------------------------------------------------------------------
module seq_muldiv
   import seq_alu_pkg::*;
#(
   parameter int N = 4
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         start,
   input  md_mode_t     mode,
   input  logic [N-1:0] a,
   input  logic [N-1:0] b,
   output logic [N-1:0] lo,
   output logic [N-1:0] hi,
   output logic         ready
);

   localparam int CW = $clog2(N + 1);

   logic [N-1:0]  r_lo;
   logic [N-1:0]  r_hi;
   logic [N-1:0]  r_b;
   md_mode_t      r_mode;
   logic [CW-1:0] r_cnt;
   logic          r_valid;

   logic [N-1:0]  w_cur_lo;
   logic [N-1:0]  w_cur_hi;
   logic [N-1:0]  w_cur_b;
   md_mode_t      w_cur_mode;
   logic [N:0]    w_sum;
   logic [N:0]    w_shift;
   logic [N:0]    w_diff;
   logic [N-1:0]  w_nxt_lo;
   logic [N-1:0]  w_nxt_hi;

   // One datapath step, fed either by the fresh operands (start) or by the
   // running registers.
   // NOTE: every signal written here gets a default first, otherwise a path
   // that skips an assignment would infer a latch.
   always_comb begin
      w_cur_lo   = start ? a      : r_lo;
      w_cur_hi   = start ? '0     : r_hi;
      w_cur_b    = start ? b      : r_b;
      w_cur_mode = start ? mode   : r_mode;
      w_sum      = '0;
      w_shift    = '0;
      w_diff     = '0;
      w_nxt_lo   = w_cur_lo;
      w_nxt_hi   = w_cur_hi;
      if (w_cur_mode == MD_MUL) begin
         // {hi,lo} shifts right; lo's LSB selects whether b is added to hi.
         w_sum    = {1'b0, w_cur_hi} + (w_cur_lo[0] ? {1'b0, w_cur_b} : '0);
         w_nxt_hi = w_sum[N:1];
         w_nxt_lo = {w_sum[0], w_cur_lo[N-1:1]};
      end else begin
         // Partial remainder < b, so the shifted value fits N+1 bits and bit N
         // of the trial difference is the borrow.
         w_shift = {w_cur_hi, w_cur_lo[N-1]};
         w_diff  = w_shift - {1'b0, w_cur_b};
         if (!w_diff[N]) begin
            w_nxt_hi = w_diff[N-1:0];
            w_nxt_lo = {w_cur_lo[N-2:0], 1'b1};
         end else begin
            w_nxt_hi = w_shift[N-1:0];
            w_nxt_lo = {w_cur_lo[N-2:0], 1'b0};
         end
      end
   end

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples the pre-edge values regardless of statement order.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_lo    <= '0;
         r_hi    <= '0;
         r_b     <= '0;
         r_mode  <= MD_MUL;
         r_cnt   <= '0;
         r_valid <= 1'b0;
      end else if (start) begin
         r_lo    <= w_nxt_lo;
         r_hi    <= w_nxt_hi;
         r_b     <= b;
         r_mode  <= mode;
         r_cnt   <= CW'(N - 1);
         r_valid <= 1'b1;
      end else if (r_cnt != '0) begin
         r_lo    <= w_nxt_lo;
         r_hi    <= w_nxt_hi;
         r_cnt   <= r_cnt - 1'b1;
      end
   end

   assign lo    = r_lo;
   assign hi    = r_hi;
   assign ready = r_valid && (r_cnt == '0);

endmodule

// File: rtl/seq_alu.sv
// -----------------------------------------------------------------------------
// seq_alu
//   Multi-cycle N-bit ALU. Single-cycle ops complete with `done` in the cycle
//   after the start edge; MUL/DIV (b!=0) iterate and complete N+1 cycles after
//   it. Results and {N,Z,C,V} flags are registered and hold until the next
//   operation completes.
//   Build option: define SEQ_ALU_MULDIV_EN to compile in the MUL/DIV datapath;
//   without it opcodes 8 and 9 are reported as unsupported.
//   Ports:
//     clk, rst_n        : clock, asynchronous active-low reset
//     start, op, a, b   : request strobe (ignored while busy), opcode, operands
//     result, result_hi : low result / quotient, MUL high half / remainder
//     flags             : {N,Z,C,V}
//     err               : divide-by-zero or unsupported opcode
//     busy, done        : operation in flight, one-cycle completion pulse
// -----------------------------------------------------------------------------
module seq_alu
   import seq_alu_pkg::*;
#(
   parameter int N = 4
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         start,
   input  logic [3:0]   op,
   input  logic [N-1:0] a,
   input  logic [N-1:0] b,
   output logic [N-1:0] result,
   output logic [N-1:0] result_hi,
   output logic [3:0]   flags,
   output logic         err,
   output logic         busy,
   output logic         done
);

   localparam int SW = $clog2(N);

   state_t        r_state;
   state_t        w_state_nxt;
   logic [N-1:0]  r_result;
   logic [N-1:0]  r_result_hi;
   logic [3:0]    r_flags;
   logic          r_err;
   logic          r_busy;
   logic          r_done;

   logic          w_accept;
   logic          w_iter_op;
   logic [N:0]    w_add;
   logic [N:0]    w_sub;
   logic [SW-1:0] w_shamt;
   logic          w_sh_big;
   logic [N:0]    w_shl;
   logic [N:0]    w_shr;

   logic [N-1:0]  w_alu_res;
   logic [N-1:0]  w_alu_hi;
   logic          w_alu_c;
   logic          w_alu_v;
   logic          w_alu_err;
   logic          w_alu_unsup;

   logic          w_cap;
   logic [N-1:0]  w_cap_res;
   logic [N-1:0]  w_cap_hi;
   logic [3:0]    w_cap_flags;
   logic          w_cap_err;

   function automatic logic [3:0] make_flags(input logic [N-1:0] res,
                                             input logic c, input logic v);
      logic [3:0] f;
      f         = '0;
      f[FLAG_N] = res[N-1];
      f[FLAG_Z] = (res == '0);
      f[FLAG_C] = c;
      f[FLAG_V] = v;
      return f;
   endfunction

   assign w_accept = (r_state == IDLE) && start;

`ifdef SEQ_ALU_MULDIV_EN
   localparam int CW = $clog2(N + 1);

   logic [CW-1:0] r_cnt;
   logic          r_is_div;
   logic          w_md_start;
   md_mode_t      w_md_mode;
   logic [N-1:0]  w_md_lo;
   logic [N-1:0]  w_md_hi;
   logic          w_md_ready;

   assign w_iter_op  = (op == OP_MUL) || ((op == OP_DIV) && (b != '0));
   assign w_md_start = w_accept && w_iter_op;
   assign w_md_mode  = (op == OP_DIV) ? MD_DIV : MD_MUL;

   seq_muldiv #(.N(N)) u_muldiv (
      .clk   (clk),
      .rst_n (rst_n),
      .start (w_md_start),
      .mode  (w_md_mode),
      .a     (a),
      .b     (b),
      .lo    (w_md_lo),
      .hi    (w_md_hi),
      .ready (w_md_ready)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_cnt    <= '0;
         r_is_div <= 1'b0;
      end else if (w_md_start) begin
         r_cnt    <= CW'(N);
         r_is_div <= (op == OP_DIV);
      end else if (r_state == ITER) begin
         r_cnt    <= r_cnt - 1'b1;
      end
   end
`else
   assign w_iter_op = 1'b0;
`endif

   // ---------------- single-cycle datapath (from the live inputs) -----------
   assign w_add    = {1'b0, a} + {1'b0, b};
   assign w_sub    = {1'b0, a} - {1'b0, b};
   assign w_shamt  = b[SW-1:0];
   assign w_sh_big = (32'(w_shamt) >= N);
   // The extra bit on each side captures the last bit shifted out.
   assign w_shl    = {1'b0, a} << w_shamt;
   assign w_shr    = {a, 1'b0} >> w_shamt;

   always_comb begin
      w_alu_res   = '0;
      w_alu_hi    = '0;
      w_alu_c     = 1'b0;
      w_alu_v     = 1'b0;
      w_alu_err   = 1'b0;
      w_alu_unsup = 1'b0;
      case (op)
         OP_ADD: begin
            w_alu_res = w_add[N-1:0];
            w_alu_c   = w_add[N];
            w_alu_v   = (a[N-1] == b[N-1]) && (w_add[N-1] != a[N-1]);
         end
         OP_SUB: begin
            w_alu_res = w_sub[N-1:0];
            w_alu_c   = ~w_sub[N];
            w_alu_v   = (a[N-1] != b[N-1]) && (w_sub[N-1] != a[N-1]);
         end
         OP_AND: w_alu_res = a & b;
         OP_OR:  w_alu_res = a | b;
         OP_XOR: w_alu_res = a ^ b;
         OP_NOT: w_alu_res = ~a;
         OP_SHL: begin
            if (!w_sh_big) begin
               w_alu_res = w_shl[N-1:0];
               w_alu_c   = w_shl[N];
            end
         end
         OP_SHR: begin
            if (!w_sh_big) begin
               w_alu_res = w_shr[N:1];
               w_alu_c   = w_shr[0];
            end
         end
`ifdef SEQ_ALU_MULDIV_EN
         // Only divide-by-zero completes in one cycle; the rest iterate.
         OP_DIV: begin
            if (b == '0) begin
               w_alu_res = '1;
               w_alu_hi  = a;
               w_alu_err = 1'b1;
            end
         end
         OP_MUL: begin
         end
`endif
         default: begin
            w_alu_err   = 1'b1;
            w_alu_unsup = 1'b1;
         end
      endcase
   end

   // ---------------- FSM: next state ----------------------------------------
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         IDLE: if (start) w_state_nxt = w_iter_op ? ITER : DONE;
`ifdef SEQ_ALU_MULDIV_EN
         ITER: if ((r_cnt == CW'(1)) && w_md_ready) w_state_nxt = DONE;
`endif
         DONE:    w_state_nxt = IDLE;
         default: w_state_nxt = IDLE;
      endcase
   end

   // ---------------- FSM: outputs (capture enable and values) ---------------
   always_comb begin
      w_cap       = 1'b0;
      w_cap_res   = w_alu_res;
      w_cap_hi    = w_alu_hi;
      w_cap_err   = w_alu_err;
      w_cap_flags = w_alu_unsup ? 4'b0000 : make_flags(w_alu_res, w_alu_c, w_alu_v);
      if (w_accept && !w_iter_op) begin
         w_cap = 1'b1;
      end
`ifdef SEQ_ALU_MULDIV_EN
      if ((r_state == ITER) && (w_state_nxt == DONE)) begin
         w_cap       = 1'b1;
         w_cap_res   = w_md_lo;
         w_cap_hi    = w_md_hi;
         w_cap_err   = 1'b0;
         w_cap_flags = make_flags(w_md_lo, !r_is_div && (w_md_hi != '0), 1'b0);
      end
`endif
   end

   // ---------------- FSM: state register ------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= IDLE;
      else        r_state <= w_state_nxt;
   end

   // ---------------- output registers ---------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_result    <= '0;
         r_result_hi <= '0;
         r_flags     <= '0;
         r_err       <= 1'b0;
         r_busy      <= 1'b0;
         r_done      <= 1'b0;
      end else begin
         r_busy <= (w_state_nxt != IDLE);
         r_done <= (w_state_nxt == DONE);
         if (w_cap) begin
            r_result    <= w_cap_res;
            r_result_hi <= w_cap_hi;
            r_flags     <= w_cap_flags;
            r_err       <= w_cap_err;
         end
      end
   end

   assign result    = r_result;
   assign result_hi = r_result_hi;
   assign flags     = r_flags;
   assign err       = r_err;
   assign busy      = r_busy;
   assign done      = r_done;

endmodule

// File: tb/tb_seq_alu.sv
// -----------------------------------------------------------------------------
// tb_seq_alu
//   Directed bench for seq_alu with N=4. Each request pushes its expected
//   outcome (from an integer reference model) onto a scoreboard queue; the
//   entry is popped and compared when `done` arrives. Expectations follow the
//   SEQ_ALU_MULDIV_EN build option.
// -----------------------------------------------------------------------------
module tb_seq_alu;

   localparam int NW = 4;

   logic          clk;
   logic          rst_n;
   logic          start;
   logic [3:0]    op;
   logic [NW-1:0] a;
   logic [NW-1:0] b;
   logic [NW-1:0] result;
   logic [NW-1:0] result_hi;
   logic [3:0]    flags;
   logic          err;
   logic          busy;
   logic          done;

   int n_vec  = 0;
   int n_miss = 0;

   typedef struct {
      logic [3:0] res;
      logic [3:0] hi;
      logic [3:0] flags;
      logic       err;
      int         lat;
   } exp_t;

   exp_t  sb_q[$];
   string tag_q[$];

   seq_alu #(.N(NW)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .start     (start),
      .op        (op),
      .a         (a),
      .b         (b),
      .result    (result),
      .result_hi (result_hi),
      .flags     (flags),
      .err       (err),
      .busy      (busy),
      .done      (done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_miss++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Integer reference: operands treated as 0..15, signed view for V only.
   function automatic exp_t model(input int opc, input int x, input int y);
      exp_t e;
      int   r, h, s, sx, sy, amt;
      bit   c, v, er, unsup;
      r = 0; h = 0; c = 0; v = 0; er = 0; unsup = 0;
      e.lat = 1;
      sx  = (x > 7) ? x - 16 : x;
      sy  = (y > 7) ? y - 16 : y;
      amt = y % 4;
      case (opc)
         0: begin s = x + y; r = s % 16; c = (s > 15); v = ((sx + sy) > 7) || ((sx + sy) < -8); end
         1: begin r = (x - y + 16) % 16; c = (x >= y); v = ((sx - sy) > 7) || ((sx - sy) < -8); end
         2: r = x & y;
         3: r = x | y;
         4: r = x ^ y;
         5: r = 15 - x;
         6: begin r = (x << amt) % 16; c = (amt == 0) ? 1'b0 : ((x >> (4 - amt)) % 2 == 1); end
         7: begin r = x >> amt;        c = (amt == 0) ? 1'b0 : ((x >> (amt - 1)) % 2 == 1); end
`ifdef SEQ_ALU_MULDIV_EN
         8: begin r = (x * y) % 16; h = (x * y) / 16; c = (h != 0); e.lat = 5; end
         9: begin
            if (y == 0) begin r = 15; h = x; er = 1; end
            else begin r = x / y; h = x % y; e.lat = 5; end
         end
`endif
         default: begin er = 1; unsup = 1; end
      endcase
      e.res   = r[3:0];
      e.hi    = h[3:0];
      e.err   = er;
      e.flags = unsup ? 4'b0000 : {r[3], (r == 0), c, v};
      return e;
   endfunction

   // Called at a falling edge; returns at the falling edge of the cycle after
   // done, so back-to-back calls exercise maximum throughput.
   task automatic run_op(input logic [3:0] op_i, input logic [3:0] a_i, input logic [3:0] b_i);
      exp_t  e;
      string t;
      int    lat;
      sb_q.push_back(model(int'(op_i), int'(a_i), int'(b_i)));
      tag_q.push_back($sformatf("op%0d a=%0d b=%0d", op_i, a_i, b_i));
      start = 1'b1; op = op_i; a = a_i; b = b_i;
      @(negedge clk);
      start = 1'b0;
      lat = 1;
      check("busy after start", busy, 1);
      while (!done && lat < 20) begin
         @(negedge clk);
         lat++;
         check("busy while running", busy, 1);
      end
      e = sb_q.pop_front();
      t = tag_q.pop_front();
      check({t, " latency"}, lat, e.lat);
      check({t, " result"}, result, e.res);
      check({t, " result_hi"}, result_hi, e.hi);
      check({t, " flags"}, flags, e.flags);
      check({t, " err"}, err, e.err);
      @(negedge clk);
      check({t, " busy after done"}, busy, 0);
      check({t, " done single pulse"}, done, 0);
      check({t, " result holds"}, result, e.res);
   endtask

   initial begin
      int n_done;
      int n_done_exp;
      rst_n = 1'b0; start = 1'b0; op = '0; a = '0; b = '0;
      repeat (2) @(negedge clk);
      check("reset result", result, 0);
      check("reset result_hi", result_hi, 0);
      check("reset flags", flags, 0);
      check("reset err", err, 0);
      check("reset busy", busy, 0);
      check("reset done", done, 0);
      rst_n = 1'b1;
      @(negedge clk);

      run_op(4'd0, 4'd7, 4'd9);    // ADD wrap to zero, C=1
      run_op(4'd0, 4'd8, 4'd8);    // ADD signed overflow
      run_op(4'd1, 4'd4, 4'd5);    // SUB borrow
      run_op(4'd1, 4'd8, 4'd1);    // SUB signed overflow
      run_op(4'd2, 4'd12, 4'd10);  // AND
      run_op(4'd3, 4'd12, 4'd3);   // OR
      run_op(4'd4, 4'd15, 4'd5);   // XOR
      run_op(4'd5, 4'd6, 4'd0);    // NOT
      run_op(4'd6, 4'd13, 4'd2);   // SHL, carry from a[2]
      run_op(4'd7, 4'd13, 4'd1);   // SHR, carry from a[0]
      run_op(4'd7, 4'd13, 4'd4);   // SHR amount field 0
      run_op(4'd8, 4'd15, 4'd15);  // MUL
      run_op(4'd8, 4'd3, 4'd3);    // MUL
      run_op(4'd9, 4'd13, 4'd4);   // DIV
      run_op(4'd9, 4'd9, 4'd0);    // DIV by zero
      run_op(4'd12, 4'd5, 4'd5);   // unsupported
      run_op(4'd15, 4'd1, 4'd1);   // unsupported

      // MUL, a start with ADD while busy, then reset in cycle 3.
`ifdef SEQ_ALU_MULDIV_EN
      n_done_exp = 0;
`else
      n_done_exp = 1;
`endif
      n_done = 0;
      start = 1'b1; op = 4'd8; a = 4'd15; b = 4'd15;
      for (int k = 1; k <= 3; k++) begin
         @(negedge clk);
         if (done) n_done++;
         if (k == 1) begin
            op = 4'd0; a = 4'd1; b = 4'd1;
         end else begin
            start = 1'b0;
         end
      end
      check("done pulses before reset", n_done, n_done_exp);
      #1 rst_n = 1'b0;
      #1;
      check("async reset result", result, 0);
      check("async reset result_hi", result_hi, 0);
      check("async reset flags", flags, 0);
      check("async reset err", err, 0);
      check("async reset busy", busy, 0);
      check("async reset done", done, 0);
      @(negedge clk);
      rst_n = 1'b1;
      n_done = 0;
      for (int k = 0; k < 8; k++) begin
         @(negedge clk);
         if (done) n_done++;
      end
      check("no done after abort", n_done, 0);
      run_op(4'd0, 4'd2, 4'd3);    // first start after reset

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule
